// File: rtl/arb2_req_fifo.sv
// arb2_req_fifo
//   Upstream feeder for a two-client arbiter. Each client has its own request
//   FIFO. The block raises reqk while FIFO k holds data, pops the head entry
//   when the arbiter grants it, and presents that entry on a registered output
//   that is tagged with its source client.
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-low reset
//   push1/data1       client 1 write strobe and payload
//   push2/data2       client 2 write strobe and payload
//   full1/full2       FIFO k holds DEPTH entries
//   req1/req2         FIFO k is non-empty (request to the arbiter)
//   gnt1/gnt2         grants from the arbiter
//   out_valid         one-cycle pulse for each popped entry
//   out_data/out_src  payload of the popped entry and its source (0 = client 1)
//   ovf               sticky: a push arrived while the FIFO was full
//   gerr              sticky: both grants were high, or a grant hit an empty FIFO
module arb2_req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push1,
    input  logic [DW-1:0] data1,
    input  logic          push2,
    input  logic [DW-1:0] data2,
    output logic          full1,
    output logic          full2,
    output logic          req1,
    output logic          req2,
    input  logic          gnt1,
    input  logic          gnt2,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          ovf,
    output logic          gerr
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [1:0]         push_v;
    logic [1:0][DW-1:0] data_v;
    logic [1:0]         gnt_v;
    logic [1:0]         req_v;
    logic [1:0]         full_v;
    logic [1:0]         pop_v;
    logic [1:0][DW-1:0] head_v;

    assign push_v = {push2, push1};
    assign data_v = {data2, data1};
    assign gnt_v  = {gnt2, gnt1};

    // Client 1 wins when both are granted; a grant to an empty FIFO is ignored.
    always_comb begin
        pop_v    = '0;
        pop_v[0] = gnt_v[0] & req_v[0];
        pop_v[1] = gnt_v[1] & req_v[1] & ~pop_v[0];
    end

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [DW-1:0] mem_q [DEPTH];
        logic [DW-1:0] mem_d [DEPTH];
        logic [AW-1:0] wr_q, wr_d;
        logic [AW-1:0] rd_q, rd_d;
        logic [AW:0]   cnt_q, cnt_d;
        logic          wr_en;

        // req/full come from the registered count only, so neither a push nor
        // a grant can reach req combinationally.
        assign req_v[k]  = (cnt_q != '0);
        assign full_v[k] = (cnt_q == DEPTH_C);
        assign head_v[k] = mem_q[rd_q];

        always_comb begin
            // Full is judged on the pre-edge count: a push while full is
            // dropped even if the same edge pops an entry.
            wr_en = push_v[k] & ~full_v[k];
            mem_d = mem_q;
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (wr_en) begin
                mem_d[wr_q] = data_v[k];
                wr_d        = wr_q + 1'b1;
            end
            if (pop_v[k]) begin
                rd_d = rd_q + 1'b1;
            end
            case ({wr_en, pop_v[k]})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        // Pointers are log2(DEPTH) wide, so they wrap naturally.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        // Storage needs no reset: an entry is only read after it was written.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end
    end

    assign req1  = req_v[0];
    assign req2  = req_v[1];
    assign full1 = full_v[0];
    assign full2 = full_v[1];

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          out_src_q,   out_src_d;
    logic          ovf_q,       ovf_d;
    logic          gerr_q,      gerr_d;

    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (pop_v[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = head_v[0];
            out_src_d   = 1'b0;
        end else if (pop_v[1]) begin
            out_valid_d = 1'b1;
            out_data_d  = head_v[1];
            out_src_d   = 1'b1;
        end
        ovf_d  = ovf_q | (|(push_v & full_v));
        gerr_d = gerr_q | (gnt_v[0] & gnt_v[1]) | (|(gnt_v & ~req_v));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            ovf_q       <= 1'b0;
            gerr_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ovf_q       <= ovf_d;
            gerr_q      <= gerr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign ovf       = ovf_q;
    assign gerr      = gerr_q;

endmodule

// File: tb/tb_arb2_req_fifo.sv
module tb_arb2_req_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push1, push2, gnt1, gnt2;
    logic [DW-1:0] data1, data2;
    logic          full1, full2, req1, req2;
    logic          out_valid, out_src, ovf, gerr;
    logic [DW-1:0] out_data;

    arb2_req_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .push1(push1), .data1(data1), .push2(push2), .data2(data2),
        .full1(full1), .full2(full2), .req1(req1), .req2(req2),
        .gnt1(gnt1), .gnt2(gnt2),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .ovf(ovf), .gerr(gerr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per client plus the registered output state.
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          m_valid, m_src, m_ovf, m_gerr;
    logic [DW-1:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q2.delete();
        m_valid = 0; m_src = 0; m_ovf = 0; m_gerr = 0; m_data = '0;
    endtask

    // One clock of the spec's rules, evaluated on pre-edge state.
    task automatic model_step(input logic p1, input logic [DW-1:0] d1,
                              input logic p2, input logic [DW-1:0] d2,
                              input logic g1, input logic g2);
        bit r1, r2, f1, f2, pp1, pp2;
        r1 = q1.size() != 0;
        r2 = q2.size() != 0;
        f1 = q1.size() == DEPTH;
        f2 = q2.size() == DEPTH;
        pp1 = g1 && r1;
        pp2 = g2 && r2 && !pp1;
        if ((g1 && g2) || (g1 && !r1) || (g2 && !r2)) m_gerr = 1;
        if ((p1 && f1) || (p2 && f2)) m_ovf = 1;
        if (pp1) begin
            m_valid = 1; m_data = q1.pop_front(); m_src = 0;
        end else if (pp2) begin
            m_valid = 1; m_data = q2.pop_front(); m_src = 1;
        end else begin
            m_valid = 0;
        end
        if (p1 && !f1) q1.push_back(d1);
        if (p2 && !f2) q2.push_back(d2);
    endtask

    task automatic cyc(input logic p1, input logic [DW-1:0] d1,
                       input logic p2, input logic [DW-1:0] d2,
                       input logic g1, input logic g2);
        push1 = p1; data1 = d1; push2 = p2; data2 = d2; gnt1 = g1; gnt2 = g2;
        model_step(p1, d1, p2, d2, g1, g2);
        @(posedge clk);
        #1;
        push1 = 0; push2 = 0; gnt1 = 0; gnt2 = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req1"},      32'(req1),      32'(q1.size() != 0));
        chk({tag, ".req2"},      32'(req2),      32'(q2.size() != 0));
        chk({tag, ".full1"},     32'(full1),     32'(q1.size() == DEPTH));
        chk({tag, ".full2"},     32'(full2),     32'(q2.size() == DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
        chk({tag, ".out_src"},   32'(out_src),   32'(m_src));
        chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
        chk({tag, ".gerr"},      32'(gerr),      32'(m_gerr));
    endtask

    task automatic do_reset();
        rst = 0;
        push1 = 0; push2 = 0; gnt1 = 0; gnt2 = 0; data1 = '0; data2 = '0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    typedef struct {
        logic p1; logic [7:0] d1; logic p2; logic [7:0] d2; logic g1; logic g2;
        logic r1; logic r2; logic f1; logic f2; logic v; logic [7:0] d; logic s; logic o; logic e;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // p1 d1 p2 d2 g1 g2 | r1 r2 f1 f2 v d s ovf gerr (values after the edge)
        tbl[0]  = '{0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 8'h11, 0, 8'h00, 0, 0,  1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[2]  = '{0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 1, 8'h11, 0, 0, 0};
        tbl[3]  = '{0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 8'h11, 0, 0, 0};
        tbl[4]  = '{0, 8'h00, 1, 8'hA0, 0, 0,  0, 1, 0, 0, 0, 8'h11, 0, 0, 0};
        tbl[5]  = '{0, 8'h00, 1, 8'hA1, 0, 0,  0, 1, 0, 0, 0, 8'h11, 0, 0, 0};
        tbl[6]  = '{0, 8'h00, 1, 8'hA2, 0, 0,  0, 1, 0, 0, 0, 8'h11, 0, 0, 0};
        tbl[7]  = '{0, 8'h00, 1, 8'hA3, 0, 0,  0, 1, 0, 1, 0, 8'h11, 0, 0, 0};
        tbl[8]  = '{0, 8'h00, 1, 8'hA4, 0, 0,  0, 1, 0, 1, 0, 8'h11, 0, 1, 0};
        tbl[9]  = '{0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 0, 0, 1, 8'hA0, 1, 1, 0};
        tbl[10] = '{0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 0, 0, 1, 8'hA1, 1, 1, 0};
        tbl[11] = '{0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 0, 0, 1, 8'hA2, 1, 1, 0};
        tbl[12] = '{0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 0, 1, 8'hA3, 1, 1, 0};
        tbl[13] = '{0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 0, 0, 8'hA3, 1, 1, 1};
        tbl[14] = '{0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 8'hA3, 1, 1, 1};

        // Reset state
        rst = 0;
        push1 = 0; push2 = 0; gnt1 = 0; gnt2 = 0; data1 = '0; data2 = '0;
        model_clear();
        @(posedge clk); #1;
        check_model("reset");
        rst = 1;

        // Table: basic push/pop, fill/overflow client 2, grant to empty FIFO
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].p1, tbl[i].d1, tbl[i].p2, tbl[i].d2, tbl[i].g1, tbl[i].g2);
            chk($sformatf("tbl%0d.req1", i),  32'(req1),      32'(tbl[i].r1));
            chk($sformatf("tbl%0d.req2", i),  32'(req2),      32'(tbl[i].r2));
            chk($sformatf("tbl%0d.full1", i), 32'(full1),     32'(tbl[i].f1));
            chk($sformatf("tbl%0d.full2", i), 32'(full2),     32'(tbl[i].f2));
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d.data", i),  32'(out_data),  32'(tbl[i].d));
            chk($sformatf("tbl%0d.src", i),   32'(out_src),   32'(tbl[i].s));
            chk($sformatf("tbl%0d.ovf", i),   32'(ovf),       32'(tbl[i].o));
            chk($sformatf("tbl%0d.gerr", i),  32'(gerr),      32'(tbl[i].e));
        end

        // Full client 1 with same-cycle push and grant: push dropped, count 3
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hB0 + i), 0, 0, 0, 0);
        chk("fullpop.full1_before", 32'(full1), 32'd1);
        cyc(1, 8'hB4, 0, 0, 1, 0);
        check_model("fullpop");
        chk("fullpop.data", 32'(out_data), 32'hB0);
        chk("fullpop.ovf", 32'(ovf), 32'd1);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            check_model("fullpop.drain");
            chk("fullpop.drain_data", 32'(out_data), 32'(8'hB0 + i));
        end
        chk("fullpop.req1_empty", 32'(req1), 32'd0);

        // Count 2 with push+grant: count stays 2, order preserved
        do_reset();
        cyc(1, 8'hC0, 0, 0, 0, 0);
        cyc(1, 8'hC1, 0, 0, 0, 0);
        cyc(1, 8'hC2, 0, 0, 1, 0);
        check_model("pushpop");
        chk("pushpop.data", 32'(out_data), 32'hC0);
        for (int i = 1; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            check_model("pushpop.drain");
            chk("pushpop.drain_data", 32'(out_data), 32'(8'hC0 + i));
        end
        chk("pushpop.req1_empty", 32'(req1), 32'd0);

        // Both grants together: client 1 wins, gerr set, client 2 untouched
        do_reset();
        cyc(1, 8'hD1, 1, 8'hD2, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        check_model("both");
        chk("both.src", 32'(out_src), 32'd0);
        chk("both.gerr", 32'(gerr), 32'd1);
        chk("both.req2", 32'(req2), 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        check_model("both.gnt2");
        chk("both.data2", 32'(out_data), 32'hD2);

        // Pointer wrap: alternate push/pop of 0..9 on client 1
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(i), 0, 0, 0, 0);
            chk("wrap.full1", 32'(full1), 32'd0);
            cyc(0, 0, 0, 0, 1, 0);
            check_model("wrap");
            chk("wrap.data", 32'(out_data), 32'(i));
        end
        chk("wrap.ovf", 32'(ovf), 32'd0);

        // Asynchronous reset mid-operation with 3 stored entries
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'hE0 + i), 0, 0, 0, 0);
        #2;
        rst = 0;
        #1;
        chk("async.req1", 32'(req1), 32'd0);
        chk("async.valid", 32'(out_valid), 32'd0);
        model_clear();
        @(posedge clk); #3;
        rst = 1;
        @(posedge clk); #1;
        check_model("async.idle");
        cyc(0, 0, 0, 0, 1, 0);
        check_model("async.stale_gnt");
        do_reset();
        cyc(1, 8'h77, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check_model("async.new");
        chk("async.new_data", 32'(out_data), 32'h77);

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int unsigned ra, rb;
            logic g1, g2;
            ra = $urandom_range(0, 99);
            rb = $urandom_range(0, 99);
            g1 = (q1.size() != 0) ? (ra < 55) : (ra < 2);
            g2 = (q2.size() != 0) ? (rb < 55) : (rb < 2);
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), g1, g2);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
